// File: rtl/clk_rst_seq_pkg.sv
// clk_rst_seq_pkg: shared state encoding and constants for the reset sequencer
package clk_rst_seq_pkg;
  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_PLL_RST, ST_SYS_REL, ST_RUN} state_e;
  localparam int RELOCK_W = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d};
  end
  assign q = sync_q;
endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: qualifies PLL lock, stages sys/periph reset release, pulses PLL reset on lock timeout
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lock,
  output logic                pll_reset,
  output logic                sys_rst_n,
  output logic                periph_rst_n,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_count
);
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int GW = $clog2(STAGGER_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(PLL_RST_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] STAG_LAST = GW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PRST_LAST = PW'(PLL_RST_CYCLES - 1);

  logic lock_s;
  state_e state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [GW-1:0] stag_q, stag_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] prst_q, prst_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic pll_reset_q, sys_rst_n_q, periph_rst_n_q, ready_q;

  sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d(lock), .q(lock_s));

  always_comb begin
    state_d  = state_q;
    stab_d   = '0;
    stag_d   = '0;
    tmo_d    = '0;
    prst_d   = '0;
    relock_d = relock_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        tmo_d  = tmo_q + 1'b1;
        if (lock_s && stab_q == STAB_LAST) state_d = ST_SYS_REL;
        else if (tmo_q == TMO_LAST) state_d = ST_PLL_RST;
      end
      ST_PLL_RST: begin
        prst_d = prst_q + 1'b1;
        if (prst_q == PRST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_SYS_REL: begin
        stag_d = stag_q + 1'b1;
        state_d = !lock_s ? ST_WAIT_LOCK : (stag_q == STAG_LAST) ? ST_RUN : ST_SYS_REL;
      end
      ST_RUN: begin
        state_d  = lock_s ? ST_RUN : ST_WAIT_LOCK;
        relock_d = (lock_s || &relock_q) ? relock_q : relock_q + 1'b1;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
    // every state change starts the next phase with fresh counters
    if (state_d != state_q) begin
      stab_d = '0;
      stag_d = '0;
      tmo_d  = '0;
      prst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_WAIT_LOCK;
      stab_q         <= '0;
      stag_q         <= '0;
      tmo_q          <= '0;
      prst_q         <= '0;
      relock_q       <= '0;
      pll_reset_q    <= 1'b0;
      sys_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      stab_q         <= stab_d;
      stag_q         <= stag_d;
      tmo_q          <= tmo_d;
      prst_q         <= prst_d;
      relock_q       <= relock_d;
      pll_reset_q    <= state_d == ST_PLL_RST;
      sys_rst_n_q    <= state_d == ST_SYS_REL || state_d == ST_RUN;
      periph_rst_n_q <= state_d == ST_RUN;
      ready_q        <= state_d == ST_RUN;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign periph_rst_n = periph_rst_n_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: event scoreboard for clk_rst_seq; expected output changes are queued with their edge number
module tb_clk_rst_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock = 1'b0;
  logic pll_reset, sys_rst_n, periph_rst_n, ready;
  logic [3:0] relock_count;
  logic [7:0] outs, prev;
  logic mon_en = 1'b0;
  int edge_n = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int e;
    logic [7:0] v;
  } ev_t;
  ev_t q[$];

  clk_rst_seq #(
    .STABLE_CYCLES(8),
    .STAGGER_CYCLES(4),
    .TIMEOUT_CYCLES(64),
    .PLL_RST_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lock(lock),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .periph_rst_n(periph_rst_n),
    .ready(ready),
    .relock_count(relock_count)
  );

  assign outs = {pll_reset, sys_rst_n, periph_rst_n, ready, relock_count};

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [7:0] pk(logic p, logic s, logic r, logic y, logic [3:0] c);
    return {p, s, r, y, c};
  endfunction

  task automatic push(int e, logic [7:0] v);
    ev_t ev;
    ev.e = e;
    ev.v = v;
    q.push_back(ev);
  endtask

  task automatic wait_to(int e);
    repeat (e - edge_n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: outs %b, expected %b", name, got, exp);
    end
  endtask

  // monitor: any change of the output bundle must match the next queued event
  always @(negedge clk) begin
    if (mon_en && outs !== prev) begin
      ev_t ev;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: edge %0d outs %b, no event expected", edge_n, outs);
      end else begin
        ev = q.pop_front();
        if (ev.e != edge_n || ev.v !== outs) begin
          fails++;
          $display("FAIL event: edge %0d outs %b, expected edge %0d outs %b", edge_n, outs, ev.e, ev.v);
        end
      end
      prev = outs;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, u, rc;
    wait_to(2);
    chk("reset_state", outs, pk(0, 0, 0, 0, 4'd0));
    prev = 8'h00;
    mon_en = 1'b1;
    wait_to(3);
    rst_n = 1'b1;
    r = 3;
    // first lock: sync 2 + stable 8, then stagger 4
    wait_to(r + 5);
    lock = 1'b1;
    push(r + 15, pk(0, 1, 0, 0, 4'd0));
    push(r + 19, pk(0, 1, 1, 1, 4'd0));
    wait_to(r + 22);
    // single-cycle drop in RUN, then a drop during SYS_REL which must not count
    t = edge_n;
    lock = 1'b0;
    push(t + 3, pk(0, 0, 0, 0, 4'd1));
    push(t + 11, pk(0, 1, 0, 0, 4'd1));
    wait_to(t + 1);
    lock = 1'b1;
    wait_to(t + 11);
    lock = 1'b0;
    push(t + 14, pk(0, 0, 0, 0, 4'd1));
    wait_to(t + 12);
    lock = 1'b1;
    push(t + 22, pk(0, 1, 0, 0, 4'd1));
    push(t + 26, pk(0, 1, 1, 1, 4'd1));
    wait_to(t + 28);
    // 19 more RUN drops: relock_count climbs to 15 and saturates
    for (int i = 2; i <= 20; i++) begin
      t = edge_n;
      rc = (i > 15) ? 15 : i;
      lock = 1'b0;
      push(t + 3, pk(0, 0, 0, 0, 4'(rc)));
      push(t + 11, pk(0, 1, 0, 0, 4'(rc)));
      push(t + 15, pk(0, 1, 1, 1, 4'(rc)));
      wait_to(t + 1);
      lock = 1'b1;
      wait_to(t + 17);
    end
    // async reset mid-RUN
    t = edge_n;
    push(t, pk(0, 0, 0, 0, 4'd0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs, pk(0, 0, 0, 0, 4'd0));
    wait_to(t + 3);
    rst_n = 1'b1;
    r = t + 3;
    push(r + 10, pk(0, 1, 0, 0, 4'd0));
    push(r + 14, pk(0, 1, 1, 1, 4'd0));
    wait_to(r + 16);
    // no lock: PLL reset pulse of 3 cycles every 64+3 edges
    t = edge_n;
    push(t, pk(0, 0, 0, 0, 4'd0));
    lock = 1'b0;
    rst_n = 1'b0;
    wait_to(t + 3);
    rst_n = 1'b1;
    r = t + 3;
    push(r + 64, pk(1, 0, 0, 0, 4'd0));
    push(r + 67, pk(0, 0, 0, 0, 4'd0));
    push(r + 131, pk(1, 0, 0, 0, 4'd0));
    push(r + 134, pk(0, 0, 0, 0, 4'd0));
    wait_to(r + 140);
    // lock glitch restarts stable qualification
    u = edge_n;
    lock = 1'b1;
    wait_to(u + 5);
    lock = 1'b0;
    wait_to(u + 6);
    lock = 1'b1;
    push(u + 16, pk(0, 1, 0, 0, 4'd0));
    push(u + 20, pk(0, 1, 1, 1, 4'd0));
    wait_to(u + 25);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: %0d left, expected 0 (next at edge %0d)", q.size(), q[0].e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
